// File: rtl/tx_scheduler.sv
// Arbitrates the USB transmitter between handshake replies and data packets.
// Enforces an inter-packet gap, gates data on buffer fill, and aborts a hung TX.
module tx_scheduler #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_DATA       = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       hs_req,
  input  logic       hs_nak,
  output logic       hs_done,
  input  logic       data_req,
  input  logic [6:0] data_size,
  input  logic [6:0] buffer_occupancy,
  output logic       data_done,
  input  logic       rx_busy,
  output logic [1:0] tx_packet,
  input  logic       tx_done,
  output logic       tx_active,
  output logic       tx_error
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0]    MAX_SIZE = 7'(MAX_DATA);

  localparam logic [1:0] PKT_IDLE = 2'b00;
  localparam logic [1:0] PKT_DATA = 2'b01;

  typedef enum logic [2:0] {
    ST_GAP,
    ST_IDLE,
    ST_HS_TX,
    ST_DATA_WAIT,
    ST_DATA_TX
  } state_t;

  state_t      state_q, state_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [6:0]  size_q, size_d;
  logic [1:0]  tx_packet_q, tx_packet_d;
  logic        tx_active_q, tx_active_d;
  logic        hs_done_q, hs_done_d;
  logic        data_done_q, data_done_d;
  logic        tx_error_q, tx_error_d;

  logic        to_expired;
  logic        grant_hs;
  logic        end_pkt;
  logic        end_err;

  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    to_cnt_d    = to_cnt_q;
    size_d      = size_q;
    tx_packet_d = tx_packet_q;
    tx_active_d = tx_active_q;
    hs_done_d   = 1'b0;
    data_done_d = 1'b0;
    tx_error_d  = 1'b0;
    grant_hs    = 1'b0;
    end_pkt     = 1'b0;
    end_err     = 1'b0;
    to_expired  = (to_cnt_q == TO_LAST);

    case (state_q)
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end

      ST_IDLE: begin
        if (!rx_busy) begin
          if (hs_req) begin
            grant_hs = 1'b1;
          end else if (data_req) begin
            size_d = data_size;
            if (data_size > MAX_SIZE) begin
              // Oversized request is rejected without touching the transmitter.
              tx_error_d  = 1'b1;
              data_done_d = 1'b1;
              state_d     = ST_GAP;
              gap_cnt_d   = '0;
            end else begin
              state_d     = ST_DATA_WAIT;
              tx_active_d = 1'b1;
              to_cnt_d    = '0;
            end
          end
        end
      end

      ST_DATA_WAIT: begin
        // A handshake may jump ahead; the data request stays pending upstream.
        if (hs_req && !rx_busy) begin
          grant_hs = 1'b1;
        end else if (buffer_occupancy >= size_q) begin
          state_d     = ST_DATA_TX;
          tx_packet_d = PKT_DATA;
          to_cnt_d    = '0;
        end else if (to_expired) begin
          end_pkt = 1'b1;
          end_err = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end

      ST_HS_TX, ST_DATA_TX: begin
        if (tx_done) begin
          end_pkt = 1'b1;
        end else if (to_expired) begin
          end_pkt = 1'b1;
          end_err = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end

      default: begin
        state_d   = ST_GAP;
        gap_cnt_d = '0;
      end
    endcase

    if (grant_hs) begin
      state_d     = ST_HS_TX;
      tx_packet_d = {1'b1, hs_nak};
      tx_active_d = 1'b1;
      to_cnt_d    = '0;
    end

    // Common exit for completion and abort; the owner is implied by the state.
    if (end_pkt) begin
      hs_done_d   = (state_q == ST_HS_TX);
      data_done_d = (state_q != ST_HS_TX);
      tx_error_d  = end_err;
      tx_packet_d = PKT_IDLE;
      tx_active_d = 1'b0;
      state_d     = ST_GAP;
      gap_cnt_d   = '0;
      to_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= ST_GAP;
      gap_cnt_q   <= '0;
      to_cnt_q    <= '0;
      size_q      <= '0;
      tx_packet_q <= PKT_IDLE;
      tx_active_q <= 1'b0;
      hs_done_q   <= 1'b0;
      data_done_q <= 1'b0;
      tx_error_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      to_cnt_q    <= to_cnt_d;
      size_q      <= size_d;
      tx_packet_q <= tx_packet_d;
      tx_active_q <= tx_active_d;
      hs_done_q   <= hs_done_d;
      data_done_q <= data_done_d;
      tx_error_q  <= tx_error_d;
    end
  end

  assign tx_packet = tx_packet_q;
  assign tx_active = tx_active_q;
  assign hs_done   = hs_done_q;
  assign data_done = data_done_q;
  assign tx_error  = tx_error_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Bench for tx_scheduler: directed scenarios with literal expectations plus a
// randomized phase, all shadowed by a cycle-level reference model.
module tb_tx_scheduler;

  localparam int GAP  = 16;
  localparam int TMO  = 4096;
  localparam int MAXD = 64;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       hs_req = 1'b0;
  logic       hs_nak = 1'b0;
  logic       data_req = 1'b0;
  logic       rx_busy = 1'b0;
  logic       tx_done = 1'b0;
  logic [6:0] data_size = 7'd0;
  logic [6:0] buffer_occupancy = 7'd0;
  logic       hs_done, data_done, tx_active, tx_error;
  logic [1:0] tx_packet;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  // Reference model: who owns the transmitter, whether it is sending, time spent.
  int m_gap_left = GAP;
  int m_owner = 0;        // 0 none, 1 handshake, 2 data
  int m_elapsed = 0;
  int m_need = 0;
  bit m_sending = 0;
  bit m_nak = 0;
  bit m_hs_pulse = 0;
  bit m_data_pulse = 0;
  bit m_err_pulse = 0;

  always #5 clk = ~clk;

  tx_scheduler dut (
    .clk(clk), .n_rst(n_rst),
    .hs_req(hs_req), .hs_nak(hs_nak), .hs_done(hs_done),
    .data_req(data_req), .data_size(data_size), .buffer_occupancy(buffer_occupancy),
    .data_done(data_done), .rx_busy(rx_busy), .tx_packet(tx_packet),
    .tx_done(tx_done), .tx_active(tx_active), .tx_error(tx_error)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic model_finish(input bit err);
    m_err_pulse = err;
    if (m_owner == 1) m_hs_pulse = 1'b1;
    else m_data_pulse = 1'b1;
    m_owner = 0;
    m_sending = 1'b0;
    m_gap_left = GAP;
  endtask

  task automatic model_grant_hs();
    m_owner = 1;
    m_nak = hs_nak;
    m_sending = 1'b1;
    m_elapsed = 0;
  endtask

  task automatic model_step();
    m_hs_pulse = 1'b0;
    m_data_pulse = 1'b0;
    m_err_pulse = 1'b0;
    if (!n_rst) begin
      m_gap_left = GAP;
      m_owner = 0;
      m_sending = 1'b0;
      m_elapsed = 0;
    end else if (m_owner == 0) begin
      if (m_gap_left > 0) m_gap_left--;
      else if (!rx_busy && hs_req) model_grant_hs();
      else if (!rx_busy && data_req) begin
        if (int'(data_size) > MAXD) begin
          m_err_pulse = 1'b1;
          m_data_pulse = 1'b1;
          m_gap_left = GAP;
        end else begin
          m_owner = 2;
          m_need = int'(data_size);
          m_sending = 1'b0;
          m_elapsed = 0;
        end
      end
    end else if (m_sending && tx_done) model_finish(1'b0);
    else if (m_owner == 2 && !m_sending && hs_req && !rx_busy) model_grant_hs();
    else if (m_owner == 2 && !m_sending && int'(buffer_occupancy) >= m_need) begin
      m_sending = 1'b1;
      m_elapsed = 0;
    end else if (m_elapsed == TMO - 1) model_finish(1'b1);
    else m_elapsed++;
  endtask

  function automatic logic [5:0] model_outputs();
    logic [1:0] pkt;
    logic act;
    pkt = 2'b00;
    if (m_owner != 0 && m_sending) pkt = (m_owner == 1) ? {1'b1, m_nak} : 2'b01;
    act = (m_owner != 0);
    return {pkt, act, m_hs_pulse, m_data_pulse, m_err_pulse};
  endfunction

  // Compare process: advance the model on each edge, check DUT on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      cyc++;
      @(negedge clk);
      check($sformatf("cycle%0d", cyc),
            {26'd0, tx_packet, tx_active, hs_done, data_done, tx_error},
            {26'd0, model_outputs()});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic wait_pkt(input string name, input logic [1:0] v, input int limit, output int n);
    n = 0;
    while (tx_packet !== v && n < limit) begin
      tick();
      n++;
    end
    if (tx_packet !== v) check({name, "_timeout"}, 32'(tx_packet), 32'(v));
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    int n;
    int cnt;

    // Reset state
    ticks(2);
    check("reset_pkt", 32'(tx_packet), 32'd0);
    check("reset_active", 32'(tx_active), 32'd0);
    check("reset_pulses", 32'({hs_done, data_done, tx_error}), 32'd0);

    // ACK after the post-reset gap
    n_rst = 1'b1;
    hs_req = 1'b1;
    hs_nak = 1'b0;
    wait_pkt("ack_grant", 2'b10, 40, n);
    check("gap_after_reset", n, 17);
    ticks(3);
    check("ack_hold", 32'(tx_packet), 32'd2);
    pulse_done();
    check("ack_done_pulse", 32'(hs_done), 32'd1);
    check("ack_release", 32'(tx_packet), 32'd0);
    hs_nak = 1'b1;
    tick();
    check("ack_done_one_cycle", 32'(hs_done), 32'd0);
    wait_pkt("regrant", 2'b11, 40, n);
    check("gap_after_done", n, 16);
    pulse_done();
    hs_req = 1'b0;

    // Both requesters at once: NAK first, data after the gap
    ticks(16);
    hs_req = 1'b1;
    hs_nak = 1'b1;
    data_req = 1'b1;
    data_size = 7'd8;
    buffer_occupancy = 7'd20;
    wait_pkt("nak_first", 2'b11, 5, n);
    check("nak_first_latency", n, 1);
    pulse_done();
    hs_req = 1'b0;
    check("nak_done", 32'(hs_done), 32'd1);
    wait_pkt("data_after_nak", 2'b01, 40, n);
    check("data_after_gap", n, 18);
    pulse_done();
    check("data_done_pulse", 32'(data_done), 32'd1);
    data_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (data_done) cnt++;
    end
    check("data_done_once", cnt, 0);

    // Occupancy gating, then a watchdog abort in DATA_TX
    data_req = 1'b1;
    data_size = 7'd10;
    buffer_occupancy = 7'd4;
    tick();
    check("wait_active", 32'(tx_active), 32'd1);
    ticks(5);
    check("wait_hold", 32'(tx_packet), 32'd0);
    buffer_occupancy = 7'd10;
    tick();
    check("occ_release", 32'(tx_packet), 32'd1);
    n = 0;
    while (!tx_error && n < 5000) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, 4096);
    check("timeout_done", 32'(data_done), 32'd1);
    check("timeout_pkt", 32'(tx_packet), 32'd0);
    data_req = 1'b0;

    // Zero-size data, tx_done on the last allowed cycle
    ticks(17);
    data_req = 1'b1;
    data_size = 7'd0;
    buffer_occupancy = 7'd0;
    ticks(2);
    check("size0_immediate", 32'(tx_packet), 32'd1);
    ticks(4095);
    check("late_hold", 32'({tx_packet, tx_error}), 32'd2);
    pulse_done();
    check("late_done", 32'({data_done, tx_error}), 32'd2);
    data_req = 1'b0;

    // Oversized request
    ticks(17);
    data_req = 1'b1;
    data_size = 7'd65;
    tick();
    data_req = 1'b0;
    check("oversize_err", 32'({tx_error, data_done}), 32'd3);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_active || tx_packet != 2'b00) cnt++;
    end
    check("oversize_quiet", cnt, 0);

    // rx_busy blocks a grant
    rx_busy = 1'b1;
    hs_req = 1'b1;
    hs_nak = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_active) cnt++;
    end
    check("rx_busy_block", cnt, 0);
    rx_busy = 1'b0;
    tick();
    check("rx_busy_release", 32'(tx_packet), 32'd2);
    pulse_done();
    hs_req = 1'b0;

    // Reset in the middle of a data packet
    ticks(17);
    data_req = 1'b1;
    data_size = 7'd5;
    buffer_occupancy = 7'd60;
    wait_pkt("pre_reset_data", 2'b01, 5, n);
    n_rst = 1'b0;
    tick();
    check("midreset_pkt", 32'(tx_packet), 32'd0);
    check("midreset_no_done", 32'({hs_done, data_done, tx_active}), 32'd0);
    n_rst = 1'b1;
    wait_pkt("post_reset_data", 2'b01, 40, n);
    check("gap_after_midreset", n, 18);
    pulse_done();
    data_req = 1'b0;

    // Randomized traffic, checked cycle by cycle against the model
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (hs_done) hs_req = 1'b0;
      else if (!hs_req && $urandom_range(0, 15) == 0) hs_req = 1'b1;
      hs_nak = 1'($urandom_range(0, 1));
      if (data_done) data_req = 1'b0;
      else if (data_req && !tx_active && $urandom_range(0, 63) == 0) data_req = 1'b0;
      else if (!data_req && $urandom_range(0, 11) == 0) begin
        data_req = 1'b1;
        data_size = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(65, 127))
                                                 : 7'($urandom_range(0, 64));
      end
      if ($urandom_range(0, 2) == 0) buffer_occupancy = 7'($urandom_range(0, 127));
      rx_busy = ($urandom_range(0, 7) == 0);
      tx_done = (tx_packet != 2'b00) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
    end
    tx_done = 1'b0;
    hs_req = 1'b0;
    data_req = 1'b0;
    ticks(4);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tx_scheduler.md
Name: tx_scheduler

Overview:
- Controller that sequences the USB transmit FSM.
- Shares the transmitter between two requesters: the RX-side handshake responder (ACK/NAK) and the AHB-side data-packet requester.
- Issues the 2-bit tx_packet command and holds it until tx_done. Enforces an inter-packet gap, gates data packets on buffer occupancy, and recovers from a hung transmitter with a watchdog.

Parameters:
GAP_CYCLES, 16, idle clocks enforced after every completed or aborted packet before the next grant
TIMEOUT_CYCLES, 4096, clocks allowed in a TX state without tx_done before abort
MAX_DATA, 64, largest legal data payload in bytes

Ports:
clk  in  1  system clock
n_rst  in  1  synchronous active-low reset
hs_req  in  1  handshake request from RX side; held high until hs_done
hs_nak  in  1  1 = send NAK, 0 = send ACK; sampled at grant
hs_done  out  1  one-cycle pulse when the handshake packet finishes or aborts
data_req  in  1  data packet request from AHB side; held high until data_done
data_size  in  7  payload bytes for the data packet; sampled at grant
buffer_occupancy  in  7  bytes currently in the TX data buffer
data_done  out  1  one-cycle pulse when the data packet finishes or aborts
rx_busy  in  1  receiver mid-packet; no new grant while high
tx_packet  out  2  command to TX FSM: 00 idle, 01 data, 10 ACK, 11 NAK
tx_done  in  1  one-cycle completion pulse from TX FSM
tx_active  out  1  high while in HS_TX, DATA_WAIT or DATA_TX
tx_error  out  1  one-cycle pulse on timeout abort or illegal data_size

Behaviour:
- All outputs are registered.
- On n_rst=0 sampled at a clk edge, every output and internal register resets: state=GAP, gap counter=0, timeout counter=0, tx_packet=00, all pulses 0, tx_active=0.
- A reset mid-packet drops tx_packet to 00 on the same edge and emits no done pulse.

States:
- GAP
  - tx_packet=00; gap counter increments each cycle.
  - When it reaches GAP_CYCLES-1, go to IDLE and clear the counter.
  - Requests are ignored in GAP.
- IDLE
  - Priority: hs_req over data_req. Neither is granted while rx_busy=1.
  - hs_req=1: latch hs_nak, go to HS_TX. tx_packet={1,hs_nak} is visible on the next cycle, i.e. 1-cycle grant latency.
  - Else data_req=1: latch data_size.
    - If the latched size exceeds MAX_DATA: pulse tx_error and data_done together, go to GAP.
    - Else go to DATA_WAIT.
- DATA_WAIT
  - tx_packet=00.
  - If buffer_occupancy >= latched size (size 0 always passes), go to DATA_TX with tx_packet=01 next cycle.
  - If hs_req=1 and rx_busy=0 first, the handshake preempts: go to HS_TX. The data request stays pending and is re-evaluated from IDLE after the handshake's gap.
  - The timeout counter runs here too.
- HS_TX / DATA_TX
  - Hold tx_packet constant until tx_done=1.
  - On tx_done: tx_packet=00 and pulse hs_done or data_done on the next cycle, then go to GAP.
- Timeout
  - The timeout counter clears on entry to HS_TX, DATA_WAIT and DATA_TX, and increments each cycle in those states.
  - At TIMEOUT_CYCLES-1 without the exit condition: pulse tx_error plus the owning requester's done pulse, set tx_packet=00, go to GAP.
  - If tx_done and timeout coincide, tx_done wins and no error is raised.
- tx_done outside HS_TX/DATA_TX is ignored.
- A request withdrawn before grant is simply not served. A request withdrawn after grant does not cancel the packet.
- Counters are sized by $clog2 of their parameter and saturate-free: they are always cleared on state exit.

Test Plan:
- Reset, wait 16 clocks, pulse hs_req=1, hs_nak=0 → tx_packet=10 one cycle after grant, held until tx_done; hs_done pulses 1 cycle after tx_done; next grant no earlier than 16 clocks later.
- hs_req and data_req both rise in IDLE, hs_nak=1 → NAK (11) sent first; data packet (01) issued only after GAP; data_done pulses once.
- data_req with data_size=10, buffer_occupancy=4 → tx_packet stays 00 in DATA_WAIT; occupancy raised to 10 → tx_packet=01 next cycle.
- data_size=0, buffer_occupancy=0 → immediate DATA_TX; data_size=65 → tx_error and data_done pulse, no tx_packet activity.
- Hold tx_done low in DATA_TX → after 4096 clocks tx_error and data_done pulse, tx_packet=00, then GAP; repeat with tx_done arriving on the final cycle → no error.
- rx_busy=1 while hs_req=1 → no grant until rx_busy falls. Assert n_rst=0 mid-DATA_TX → tx_packet=00 on that edge, no done pulse, 16-cycle gap after release.
